// File: rtl/seq_rd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_rd_pkg
//  Description : Shared types and helpers for the sequential memory burst
//                reader: FSM state encoding, skid FIFO depth and the request
//                length clamp.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_rd_pkg;

    // Burst engine states, explicitly 2 bits wide
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rd_state_e;

    // Three entries cover the one-cycle read latency plus two words of slack
    localparam int RD_FIFO_DEPTH = 3;

    // Limit a requested length to the number of words in the memory
    function automatic int unsigned clamp_len(input int unsigned len,
                                              input int unsigned max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_rd_skid_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : seq_rd_skid_fifo
//  Description : Small circular FIFO that catches read data returning from a
//                one-cycle-latency memory while the consumer stalls. The head
//                entry is presented combinationally on pop_data.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_rd_skid_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 3,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic [CNT_W-1:0]  count,
    output logic              empty
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic w_full;
    logic w_do_push;
    logic w_do_pop;

    // Pointers wrap explicitly because the depth need not be a power of two
    function automatic logic [c_PTR_W-1:0] next_ptr(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
    endfunction

    assign empty    = (r_count == '0);
    assign w_full   = (r_count == CNT_W'(DEPTH));
    assign w_do_pop = pop && !empty;
    // A push into a full FIFO is only legal when the head leaves the same cycle
    assign w_do_push = push && (!w_full || w_do_pop);
    assign pop_data = r_mem[r_rd_ptr];
    assign count    = r_count;

    // Storage: cleared on reset so the head reads as zero afterwards
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; push+pop together leaves count alone
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq_mem_burst_reader.sv
`default_nettype none
// ============================================================================
//  Module      : seq_mem_burst_reader
//  Description : Burst read engine for a synchronous-read memory. Accepts a
//                (start address, length) request, issues one read per cycle
//                under a credit limit and streams the returned words out on a
//                valid/ready interface through a small skid FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_mem_burst_reader
    import seq_rd_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int LEN_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

    localparam int unsigned c_MAX_LEN = 2 ** ADDR_W;
    localparam int          c_CNT_W   = $clog2(RD_FIFO_DEPTH + 1);

    rd_state_e         r_state;
    rd_state_e         w_state_next;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_rd_addr_hold;
    logic [LEN_W-1:0]  r_remain;
    logic              r_inflight;

    logic [LEN_W-1:0]   w_req_len_clamped;
    logic [c_CNT_W-1:0] w_count;
    logic [c_CNT_W:0]   w_outstanding;
    logic               w_empty;
    logic               w_pop;
    logic               w_credit;
    logic               w_issue;
    logic               w_accept;

    assign w_req_len_clamped = LEN_W'(clamp_len(32'(req_len), c_MAX_LEN));

    // Words owned by the engine: those queued plus the one returning now.
    // Depends only on registers, so out_ready never reaches rd_en.
    assign w_outstanding = (c_CNT_W + 1)'(w_count) + (c_CNT_W + 1)'(r_inflight);
    assign w_credit      = (w_outstanding < (c_CNT_W + 1)'(RD_FIFO_DEPTH));
    assign w_issue       = (r_state == ISSUE) && w_credit && (r_remain != '0);
    assign w_accept      = (r_state == IDLE) && req_valid;
    assign w_pop         = !w_empty && out_ready;

    // The address is driven live on an issue and otherwise holds the last one
    assign rd_addr   = w_issue ? r_addr : r_rd_addr_hold;
    assign out_valid = !w_empty;

    // Next-state and strobe outputs
    always_comb begin
        w_state_next = r_state;
        req_ready    = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        rd_en        = w_issue;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    w_state_next = (w_req_len_clamped == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (w_issue && (r_remain == LEN_W'(1))) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                // Finish in the cycle the final word leaves so done follows
                // the last handshake directly
                if (!r_inflight &&
                    (w_empty || ((w_count == c_CNT_W'(1)) && w_pop))) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Burst address/length tracking and the read-return marker
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr         <= '0;
            r_remain       <= '0;
            r_rd_addr_hold <= '0;
            r_inflight     <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_accept) begin
                r_addr   <= req_addr;
                r_remain <= w_req_len_clamped;
            end else if (w_issue) begin
                r_addr         <= r_addr + ADDR_W'(1);
                r_remain       <= r_remain - LEN_W'(1);
                r_rd_addr_hold <= r_addr;
            end
        end
    end

    seq_rd_skid_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (RD_FIFO_DEPTH),
        .CNT_W  (c_CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (r_inflight),
        .push_data (rd_data),
        .pop       (w_pop),
        .pop_data  (out_data),
        .count     (w_count),
        .empty     (w_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_seq_mem_burst_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_mem_burst_reader
//  Description : Self-checking bench for seq_mem_burst_reader with a 16x8
//                synchronous-read memory model and a word-queue reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_mem_burst_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [3:0] req_addr = '0;
    logic [4:0] req_len = '0;
    logic       rd_en;
    logic [3:0] rd_addr;
    logic [7:0] rd_data = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       busy;
    logic       done;

    logic [7:0] mem [16];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Synchronous-read memory: data appears the cycle after the strobe
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    seq_mem_burst_reader #(
        .ADDR_W (4),
        .DATA_W (8),
        .LEN_W  (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One burst from its accept cycle up to its done pulse.
    // mode 0: out_ready always 1; 1: random out_ready; 2: out_ready low cycles 3..7.
    // hold: keep presenting a second request (na, nl) while this one runs.
    task automatic do_burst(input logic [3:0] a, input logic [4:0] l, input int mode,
                            input bit hold, input logic [3:0] na, input logic [4:0] nl);
        int n, issued, popped, last_cyc, cyc;
        bit fin, seen_valid, prev_stall;
        logic [7:0] prev_data;
        logic [7:0] exp_d [$];
        logic [3:0] exp_a [$];

        n = (l > 5'd16) ? 16 : int'(l);
        for (int i = 0; i < n; i++) begin
            exp_a.push_back(4'(a + i));
            exp_d.push_back(mem[4'(a + i)]);
        end

        @(posedge clk); #1;
        req_valid = 1'b1; req_addr = a; req_len = l;
        out_ready = (mode != 1) ? 1'b1 : 1'($urandom_range(0, 1));
        @(negedge clk);
        check("req_ready_idle", req_ready, 1);

        issued = 0; popped = 0; last_cyc = -1;
        fin = 0; seen_valid = 0; prev_stall = 0; prev_data = '0;
        for (cyc = 1; cyc <= 300 && !fin; cyc++) begin
            @(posedge clk); #1;
            if (hold) begin
                req_valid = 1'b1; req_addr = na; req_len = nl;
            end else begin
                req_valid = 1'b0;
            end
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = !(cyc >= 3 && cyc < 8);
            endcase
            @(negedge clk);

            check("busy", busy, 1);
            if (hold) check("req_ready_busy", req_ready, 0);
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, prev_data);
            end
            if (mode == 2 && cyc == 7 && n >= 3) begin
                check("stall_no_rd", rd_en, 0);
                check("stall_outstanding", issued - popped, 3);
            end
            if (rd_en) begin
                if (issued < n) check("rd_addr", rd_addr, exp_a[issued]);
                else            check("extra_rd", issued, n);
                check("credit", ((issued - popped) < 3), 1);
                if (issued == 0) check("first_rd_cyc", cyc, 1);
                issued++;
            end
            if (out_valid && !seen_valid) begin
                check("first_valid_cyc", cyc, 3);
                seen_valid = 1;
            end
            if (mode == 0 && n > 0 && cyc >= 3 && cyc < n + 3)
                check("no_bubble", out_valid, 1);
            if (out_valid && out_ready) begin
                if (popped < n) check("out_data", out_data, exp_d[popped]);
                else            check("extra_word", popped, n);
                popped++;
                if (popped == n) last_cyc = cyc;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (done) begin
                check("done_cyc", cyc, (n == 0) ? 1 : last_cyc + 1);
                check("word_count", popped, n);
                check("issue_count", issued, n);
                fin = 1;
            end
        end
        check("timeout", 32'(fin), 1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'(8'h10 + i);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rd_en", rd_en, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_out_data", out_data, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic burst, wrap, backpressure, zero length, clamp
        do_burst(4'h2, 5'd4, 0, 0, '0, '0);
        do_burst(4'hE, 5'd4, 0, 0, '0, '0);
        do_burst(4'h0, 5'd8, 2, 0, '0, '0);
        do_burst(4'h3, 5'd0, 0, 0, '0, '0);
        do_burst(4'h7, 5'd31, 0, 0, '0, '0);

        // Reset while a read is in flight in DRAIN (addr 5, len 2, consumer stalled)
        @(posedge clk); #1;
        req_valid = 1'b1; req_addr = 4'h5; req_len = 5'd2; out_ready = 1'b0;
        @(negedge clk);
        check("mr_accept", req_ready, 1);
        @(posedge clk); #1; req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("mr_pre_valid", out_valid, 1);
        check("mr_rd_addr_hold", rd_addr, 4'h6);
        #2 rst = 1'b1;
        #1;
        check("mr_rd_en", rd_en, 0);
        check("mr_out_valid", out_valid, 0);
        check("mr_done", done, 0);
        check("mr_busy", busy, 0);
        check("mr_rd_addr", rd_addr, 0);
        check("mr_out_data", out_data, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        do_burst(4'h0, 5'd1, 0, 0, '0, '0);

        // Request held while busy: second burst only accepted once idle
        do_burst(4'h1, 5'd3, 1, 1, 4'h9, 5'd2);
        do_burst(4'h9, 5'd2, 0, 0, '0, '0);

        // Randomized contents, addresses, lengths and consumer stalls
        for (int b = 0; b < 12; b++) begin
            for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
            do_burst(4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)), 1, 0, '0, '0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
